pll_reconfig: RTL and testbench

PLL_RECONFIG -- requirements
Module: pll_reconfig

---
 rtl/pll_reconfig_pkg.sv | 37 +++
 rtl/pll_profile_ram.sv | 39 +++
 rtl/pll_reconfig.sv | 241 ++++++++++++++++++++++++
 tb/tb_pll_reconfig.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// -----------------------------------------------------------------------------
// pll_reconfig_pkg
// Shared definitions for the PLL reconfiguration controller: MD-port opcodes,
// the sequencer state encoding, sequence timing constants and a width helper.
// -----------------------------------------------------------------------------
package pll_reconfig_pkg;

    // MD port opcodes
    localparam logic [1:0] MD_NOP      = 2'b00;
    localparam logic [1:0] MD_WRITE    = 2'b01;
    localparam logic [1:0] MD_READ     = 2'b10;
    localparam logic [1:0] MD_SET_ADDR = 2'b11;

    // Consecutive high samples of the raw lock needed to call the PLL locked
    localparam int LOCK_QUAL_CYCLES  = 16;
    // Number of cycles the PLL reset is held before the register writes begin
    localparam int RST_ASSERT_CYCLES = 4;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RST_ASSERT = 4'd1,
        SET_ADDR   = 4'd2,
        WRITE      = 4'd3,
        READ       = 4'd4,
        CMP        = 4'd5,
        RELEASE    = 4'd6,
        WAIT_LOCK  = 4'd7,
        DONE       = 4'd8,
        FAIL       = 4'd9
    } state_e;

    // Bit width able to index n items, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_profile_ram.sv
// -----------------------------------------------------------------------------
// pll_profile_ram
// One-write / one-read synchronous byte table holding the PLL register
// profiles. Read data appears one cycle after the read address is presented.
// The table has no reset so its contents survive a controller reset.
//   clk_i    : clock
//   we_i     : write strobe
//   waddr_i  : write address
//   wdata_i  : write byte
//   raddr_i  : read address
//   rdata_o  : registered read byte
// -----------------------------------------------------------------------------
module pll_profile_ram #(
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Table write port and registered read port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pll_reconfig.sv
// -----------------------------------------------------------------------------
// pll_reconfig
// Writes a stored register profile into a PLL over its MD port, optionally
// reading every byte back, then releases the PLL reset and qualifies lock.
// A lock timeout rewrites the profile up to MAX_RETRIES times before failing.
// After reset the DEFAULT_PROFILE is applied automatically.
//   mdclk, reset               : clock, synchronous active-high reset
//   profile_sel, reconfig_req  : profile to apply, single-cycle request
//   busy, done, error          : status (done is a pulse, error is sticky)
//   cfg_we/profile/addr/data   : profile table write port (idle only)
//   pll_lock_i, pll_rst_o      : raw PLL lock, PLL reset
//   lock_o                     : qualified lock
//   md_opc, md_ainc, md_wdi    : MD opcode, auto-increment, write data
//   md_rdo                     : MD read data
// -----------------------------------------------------------------------------
module pll_reconfig
    import pll_reconfig_pkg::*;
#(
    parameter  int NUM_PROFILES     = 4,
    parameter  int REGS_PER_PROFILE = 8,
    parameter  int DEFAULT_PROFILE  = 0,
    parameter  int LOCK_TIMEOUT     = 65535,
    parameter  int MAX_RETRIES      = 3,
    parameter  int VERIFY           = 1,
    localparam int PW = clog2_min1(NUM_PROFILES),
    localparam int BW = clog2_min1(REGS_PER_PROFILE)
) (
    input  logic          mdclk,
    input  logic          reset,
    input  logic [PW-1:0] profile_sel,
    input  logic          reconfig_req,
    output logic          busy,
    output logic          done,
    output logic          error,
    input  logic          cfg_we,
    input  logic [PW-1:0] cfg_profile,
    input  logic [BW-1:0] cfg_addr,
    input  logic [7:0]    cfg_data,
    input  logic          pll_lock_i,
    output logic          pll_rst_o,
    output logic          lock_o,
    output logic [1:0]    md_opc,
    output logic          md_ainc,
    output logic [7:0]    md_wdi,
    input  logic [7:0]    md_rdo
);

    localparam int TW = clog2_min1(LOCK_TIMEOUT);
    localparam int RW = clog2_min1(MAX_RETRIES + 1);

    state_e        state_q;
    logic [1:0]    cnt_q;       // sub-phase inside a state
    logic [BW-1:0] byte_q;      // byte of the profile being written
    logic [PW-1:0] profile_q;   // profile latched at request acceptance
    logic [RW-1:0] retry_q;
    logic [TW-1:0] timer_q;     // lock-wait cycles this attempt
    logic [4:0]    lockcnt_q;   // consecutive lock-high samples
    logic          pll_rst_q;
    logic [1:0]    md_opc_q;
    logic          md_ainc_q;
    logic [7:0]    md_wdi_q;    // also the expected value for read-back
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          lock_en_q;   // idle with no error: lock passes through

    logic [7:0]    ram_rdata_s;
    logic          last_byte_s;

    // The table only accepts writes while no sequence is running
    pll_profile_ram #(
        .AW (PW + BW)
    ) u_ram (
        .clk_i   (mdclk),
        .we_i    (cfg_we & ~busy_q),
        .waddr_i ({cfg_profile, cfg_addr}),
        .wdata_i (cfg_data),
        .raddr_i ({profile_q, byte_q}),
        .rdata_o (ram_rdata_s)
    );

    assign last_byte_s = (byte_q == BW'(REGS_PER_PROFILE - 1));

    // Reconfiguration sequencer with registered outputs
    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q   <= RST_ASSERT;
            cnt_q     <= 2'd0;
            byte_q    <= '0;
            profile_q <= PW'(DEFAULT_PROFILE);
            retry_q   <= '0;
            timer_q   <= '0;
            lockcnt_q <= 5'd0;
            pll_rst_q <= 1'b1;
            md_opc_q  <= MD_NOP;
            md_ainc_q <= 1'b0;
            md_wdi_q  <= 8'h00;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            lock_en_q <= 1'b0;
        end else begin
            // Opcodes and done last exactly one cycle unless re-issued below
            md_opc_q  <= MD_NOP;
            md_ainc_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reconfig_req) begin
                        state_q   <= RST_ASSERT;
                        cnt_q     <= 2'd0;
                        profile_q <= profile_sel;
                        retry_q   <= '0;
                        pll_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        error_q   <= 1'b0;
                        lock_en_q <= 1'b0;
                    end
                end
                RST_ASSERT: begin
                    if (cnt_q == 2'(RST_ASSERT_CYCLES - 1)) begin
                        state_q  <= SET_ADDR;
                        md_opc_q <= MD_SET_ADDR;
                        md_wdi_q <= 8'h00;
                        byte_q   <= '0;
                        cnt_q    <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                SET_ADDR: begin
                    state_q <= WRITE;
                    cnt_q   <= 2'd2;
                end
                // Phases: 0 WRITE on the bus, 1 NOP gap, 2 table address
                // settles, 3 table data valid and next WRITE issued
                WRITE: begin
                    case (cnt_q)
                        2'd0: cnt_q <= 2'd1;
                        2'd1: begin
                            if (VERIFY != 0) begin
                                state_q  <= READ;
                                md_opc_q <= MD_READ;
                                cnt_q    <= 2'd0;
                            end else if (last_byte_s) begin
                                state_q   <= RELEASE;
                                pll_rst_q <= 1'b0;
                            end else begin
                                byte_q <= byte_q + BW'(1);
                                cnt_q  <= 2'd2;
                            end
                        end
                        2'd2: cnt_q <= 2'd3;
                        2'd3: begin
                            md_opc_q  <= MD_WRITE;
                            md_ainc_q <= 1'b1;
                            md_wdi_q  <= ram_rdata_s;
                            cnt_q     <= 2'd0;
                        end
                        default: cnt_q <= 2'd0;
                    endcase
                end
                // READ is on the bus in phase 0; CMP samples md_rdo two
                // cycles after it
                READ: begin
                    if (cnt_q == 2'd0) begin
                        cnt_q <= 2'd1;
                    end else begin
                        state_q <= CMP;
                        cnt_q   <= 2'd0;
                    end
                end
                CMP: begin
                    if (md_rdo != md_wdi_q) begin
                        state_q <= FAIL;
                        error_q <= 1'b1;
                    end else if (last_byte_s) begin
                        state_q   <= RELEASE;
                        pll_rst_q <= 1'b0;
                    end else begin
                        state_q <= WRITE;
                        byte_q  <= byte_q + BW'(1);
                        cnt_q   <= 2'd2;
                    end
                end
                RELEASE: begin
                    state_q   <= WAIT_LOCK;
                    timer_q   <= '0;
                    lockcnt_q <= 5'd0;
                end
                WAIT_LOCK: begin
                    if (pll_lock_i && (lockcnt_q == 5'(LOCK_QUAL_CYCLES - 1))) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                        if (retry_q == RW'(MAX_RETRIES)) begin
                            state_q <= FAIL;
                            error_q <= 1'b1;
                        end else begin
                            // Rewrite the whole profile on the next attempt
                            state_q   <= RST_ASSERT;
                            retry_q   <= retry_q + RW'(1);
                            pll_rst_q <= 1'b1;
                            cnt_q     <= 2'd0;
                        end
                    end else begin
                        timer_q   <= timer_q + TW'(1);
                        lockcnt_q <= pll_lock_i ? (lockcnt_q + 5'd1) : 5'd0;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    lock_en_q <= 1'b1;
                end
                FAIL: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    lock_en_q <= 1'b0;
                end
                default: begin
                    state_q   <= FAIL;
                    error_q   <= 1'b1;
                    busy_q    <= 1'b1;
                    lock_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign pll_rst_o = pll_rst_q;
    assign md_opc    = md_opc_q;
    assign md_ainc   = md_ainc_q;
    assign md_wdi    = md_wdi_q;
    // Raw lock passes straight through while idle and error-free
    assign lock_o    = lock_en_q & pll_lock_i;

endmodule

// File: tb/tb_pll_reconfig.sv
// -----------------------------------------------------------------------------
// tb_pll_reconfig
// Bench for pll_reconfig with a behavioural PLL/MD-port model. The MD model
// keeps a write pointer (auto-incremented by WRITE with md_ainc) and returns,
// two cycles after a READ, the register most recently written.
// -----------------------------------------------------------------------------
module tb_pll_reconfig;

    logic       mdclk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] profile_sel = 2'd0;
    logic       reconfig_req = 1'b0;
    logic       busy, done, error;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_profile = 2'd0;
    logic [2:0] cfg_addr = 3'd0;
    logic [7:0] cfg_data = 8'h00;
    logic       pll_lock_i;
    logic       pll_rst_o, lock_o;
    logic [1:0] md_opc;
    logic       md_ainc;
    logic [7:0] md_wdi;
    logic [7:0] md_rdo = 8'h00;

    always #5 mdclk = ~mdclk;

    pll_reconfig #(
        .NUM_PROFILES     (4),
        .REGS_PER_PROFILE (8),
        .DEFAULT_PROFILE  (0),
        .LOCK_TIMEOUT     (300),
        .MAX_RETRIES      (3),
        .VERIFY           (1)
    ) dut (
        .mdclk        (mdclk),
        .reset        (reset),
        .profile_sel  (profile_sel),
        .reconfig_req (reconfig_req),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cfg_we       (cfg_we),
        .cfg_profile  (cfg_profile),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .pll_lock_i   (pll_lock_i),
        .pll_rst_o    (pll_rst_o),
        .lock_o       (lock_o),
        .md_opc       (md_opc),
        .md_ainc      (md_ainc),
        .md_wdi       (md_wdi),
        .md_rdo       (md_rdo)
    );

    // ---------------- PLL / MD model ----------------
    logic [7:0] md_regs [8];
    logic [2:0] wr_ptr = 3'd0;
    logic [2:0] last_ptr = 3'd0;
    logic [7:0] rd_stage = 8'h00;
    logic [1:0] prev_opc = 2'b00;
    logic       prev_rst = 1'b1;
    logic [7:0] wr_hist [4096];
    int n_wr = 0, n_rd = 0, n_sa = 0, n_rel = 0, n_done = 0;
    int n_gap_err = 0, n_ainc_err = 0, n_sa_err = 0;
    int lock_ctr = 0;
    int bad_idx = 8;          // read-back corrupted for this register (8 = none)
    logic lock_en_m = 1'b1;   // PLL model able to lock
    logic lock_kill = 1'b0;   // force raw lock low

    assign pll_lock_i = lock_en_m & ~lock_kill & ~pll_rst_o & (lock_ctr >= 100);

    always @(posedge mdclk) begin
        md_rdo   <= rd_stage;
        prev_opc <= md_opc;
        prev_rst <= pll_rst_o;
        if (prev_opc != 2'b00 && md_opc != 2'b00) n_gap_err <= n_gap_err + 1;
        case (md_opc)
            2'b11: begin
                wr_ptr   <= md_wdi[2:0];
                last_ptr <= md_wdi[2:0];
                n_sa     <= n_sa + 1;
                if (md_wdi != 8'h00) n_sa_err <= n_sa_err + 1;
            end
            2'b01: begin
                md_regs[wr_ptr] <= md_wdi;
                if (n_wr < 4096) wr_hist[n_wr] <= md_wdi;
                n_wr     <= n_wr + 1;
                last_ptr <= wr_ptr;
                if (md_ainc) wr_ptr <= wr_ptr + 3'd1;
                else n_ainc_err <= n_ainc_err + 1;
            end
            2'b10: begin
                rd_stage <= (int'(last_ptr) == bad_idx) ? 8'hFF : md_regs[last_ptr];
                n_rd     <= n_rd + 1;
            end
            default: ;
        endcase
        if (pll_rst_o) lock_ctr <= 0;
        else if (lock_ctr < 1000) lock_ctr <= lock_ctr + 1;
        if (prev_rst && !pll_rst_o) n_rel <= n_rel + 1;
        if (done) n_done <= n_done + 1;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge mdclk);
            k++;
        end
        check({name, " reaches idle"}, 32'(busy), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge mdclk);
    endtask

    task automatic load_profile(input logic [1:0] p, input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            @(negedge mdclk);
            cfg_we = 1'b1; cfg_profile = p; cfg_addr = 3'(i); cfg_data = base + 8'(i);
        end
        @(negedge mdclk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_req(input logic [1:0] p);
        @(negedge mdclk);
        profile_sel = p; reconfig_req = 1'b1;
        @(negedge mdclk);
        reconfig_req = 1'b0;
    endtask

    // Writes from index start onward must be base, base+1, ... repeating per pass
    task automatic check_writes(input string name, input int start, input int count, input logic [7:0] base);
        int bad;
        bad = 0;
        for (int k = 0; k < count; k++)
            if (wr_hist[start + k] !== base + 8'(k % 8)) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    // Negedges from reset release until SET_ADDR is on the bus
    task automatic release_and_time_setaddr(input string name);
        int k;
        k = 0;
        reset = 1'b0;
        while (md_opc !== 2'b11 && k < 50) begin
            @(negedge mdclk);
            k++;
            if (md_opc !== 2'b11) check({name, " pll_rst held"}, 32'(pll_rst_o), 32'd1);
        end
        check({name, " SET_ADDR latency"}, 32'(k), 32'd4);
    endtask

    typedef struct {
        logic [1:0] prof;
        logic [7:0] base;
        logic       lock;
        int         bad;
        int         exp_wr;
        int         exp_rd;
        int         exp_sa;
        int         exp_rel;
        int         exp_done;
        logic       exp_err;
        logic       exp_lock_o;
    } vec_t;

    vec_t vecs [4];
    int s_wr, s_rd, s_sa, s_rel, s_done;

    initial begin
        // switch, no lock (4 passes), read-back fault on byte 3, recovery
        vecs[0] = '{prof:2'd2, base:8'hA0, lock:1'b1, bad:8, exp_wr:8,  exp_rd:8,  exp_sa:1, exp_rel:1, exp_done:1, exp_err:1'b0, exp_lock_o:1'b1};
        vecs[1] = '{prof:2'd1, base:8'h30, lock:1'b0, bad:8, exp_wr:32, exp_rd:32, exp_sa:4, exp_rel:4, exp_done:0, exp_err:1'b1, exp_lock_o:1'b0};
        vecs[2] = '{prof:2'd3, base:8'hC0, lock:1'b1, bad:3, exp_wr:4,  exp_rd:4,  exp_sa:1, exp_rel:0, exp_done:0, exp_err:1'b1, exp_lock_o:1'b0};
        vecs[3] = '{prof:2'd3, base:8'h50, lock:1'b1, bad:8, exp_wr:8,  exp_rd:8,  exp_sa:1, exp_rel:1, exp_done:1, exp_err:1'b0, exp_lock_o:1'b1};

        // ---- reset values ----
        idle_cycles(4);
        check("rst pll_rst_o", 32'(pll_rst_o), 32'd1);
        check("rst md_opc",    32'(md_opc),    32'd0);
        check("rst md_ainc",   32'(md_ainc),   32'd0);
        check("rst md_wdi",    32'(md_wdi),    32'd0);
        check("rst busy",      32'(busy),      32'd1);
        check("rst done",      32'(done),      32'd0);
        check("rst error",     32'(error),     32'd0);
        check("rst lock_o",    32'(lock_o),    32'd0);

        // ---- power-up boot with whatever the table holds ----
        release_and_time_setaddr("boot0");
        wait_idle("boot0", 3000);

        // ---- boot with profile 0 = 10..17 (table survives reset) ----
        load_profile(2'd0, 8'h10);
        @(negedge mdclk); reset = 1'b1;
        idle_cycles(3);
        s_wr = n_wr; s_rd = n_rd; s_done = n_done;
        release_and_time_setaddr("boot");
        wait_idle("boot", 3000);
        check("boot writes", 32'(n_wr - s_wr), 32'd8);
        check("boot reads",  32'(n_rd - s_rd), 32'd8);
        check_writes("boot data", s_wr, 8, 8'h10);
        check("boot done",   32'(n_done - s_done), 32'd1);
        check("boot lock_o", 32'(lock_o), 32'd1);

        // ---- raw lock drop while idle: follow it, no restart ----
        lock_kill = 1'b1;
        idle_cycles(2);
        check("drop lock_o", 32'(lock_o), 32'd0);
        idle_cycles(20);
        check("drop no restart", 32'(busy), 32'd0);
        lock_kill = 1'b0;
        idle_cycles(2);

        // ---- table-driven requests ----
        for (int v = 0; v < 4; v++) begin
            load_profile(vecs[v].prof, vecs[v].base);
            lock_en_m = vecs[v].lock;
            bad_idx   = vecs[v].bad;
            s_wr = n_wr; s_rd = n_rd; s_sa = n_sa; s_rel = n_rel; s_done = n_done;
            pulse_req(vecs[v].prof);
            check($sformatf("v%0d busy", v), 32'(busy), 32'd1);
            wait_idle($sformatf("v%0d", v), 5000);
            check($sformatf("v%0d writes", v), 32'(n_wr - s_wr), 32'(vecs[v].exp_wr));
            check($sformatf("v%0d reads", v),  32'(n_rd - s_rd), 32'(vecs[v].exp_rd));
            check($sformatf("v%0d passes", v), 32'(n_sa - s_sa), 32'(vecs[v].exp_sa));
            check($sformatf("v%0d releases", v), 32'(n_rel - s_rel), 32'(vecs[v].exp_rel));
            check($sformatf("v%0d done", v),   32'(n_done - s_done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d error", v),  32'(error), 32'(vecs[v].exp_err));
            check_writes($sformatf("v%0d data", v), s_wr, vecs[v].exp_wr, vecs[v].base);
            // Let the PLL model lock while idle; lock_o must respect error
            lock_en_m = 1'b1;
            bad_idx   = 8;
            idle_cycles(120);
            check($sformatf("v%0d lock_o", v), 32'(lock_o), 32'(vecs[v].exp_lock_o));
            check($sformatf("v%0d stays idle", v), 32'(busy), 32'd0);
        end

        // ---- request and table write while busy are dropped ----
        load_profile(2'd2, 8'hA0);
        s_wr = n_wr; s_done = n_done;
        pulse_req(2'd2);
        idle_cycles(20);
        profile_sel = 2'd1; reconfig_req = 1'b1;
        cfg_we = 1'b1; cfg_profile = 2'd2; cfg_addr = 3'd0; cfg_data = 8'h55;
        @(negedge mdclk);
        reconfig_req = 1'b0; cfg_we = 1'b0;
        wait_idle("ovl", 3000);
        idle_cycles(30);
        check("ovl writes", 32'(n_wr - s_wr), 32'd8);
        check_writes("ovl data", s_wr, 8, 8'hA0);
        check("ovl done", 32'(n_done - s_done), 32'd1);
        check("ovl no queued run", 32'(busy), 32'd0);
        s_wr = n_wr;
        pulse_req(2'd2);
        wait_idle("ovl table", 3000);
        check_writes("ovl table unchanged", s_wr, 8, 8'hA0);

        // ---- reset while writing byte 4 restarts the default profile ----
        begin
            int k;
            pulse_req(2'd2);
            k = 0;
            while (!(md_opc == 2'b01 && md_wdi == 8'hA4) && k < 500) begin
                @(negedge mdclk);
                k++;
            end
            check("rstmid reached byte 4", 32'(md_wdi), 32'hA4);
            reset = 1'b1;
            @(negedge mdclk);
            check("rstmid pll_rst_o", 32'(pll_rst_o), 32'd1);
            check("rstmid md_opc",    32'(md_opc),    32'd0);
            check("rstmid md_wdi",    32'(md_wdi),    32'd0);
            check("rstmid busy",      32'(busy),      32'd1);
            idle_cycles(2);
            s_wr = n_wr; s_done = n_done;
            release_and_time_setaddr("rstmid");
            wait_idle("rstmid", 3000);
            check("rstmid writes", 32'(n_wr - s_wr), 32'd8);
            check_writes("rstmid data", s_wr, 8, 8'h10);
            check("rstmid done", 32'(n_done - s_done), 32'd1);
        end

        // ---- bus protocol over the whole run ----
        check("opcode gap",       32'(n_gap_err),  32'd0);
        check("write auto-inc",   32'(n_ainc_err), 32'd0);
        check("set-addr to zero", 32'(n_sa_err),   32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
